// File: rtl/run_scheduler.sv
// Round-robin run controller: grants one requester at a time, starts the shared
// accelerator and cycle counter, stops on done or watchdog, and returns the count.
module run_scheduler #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] ack,
    output logic            busy,
    output logic [IDW-1:0]  grant_id,
    output logic            go_o,
    input  logic            accel_done,
    output logic            cnt_done_o,
    input  logic            cnt_counting,
    input  logic [63:0]     cnt_value,
    output logic            result_valid,
    output logic [63:0]     result_cycles,
    output logic            result_timeout,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GO    = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_grant;
    logic [31:0]      r_wd;
    logic             r_tflag;
    logic [63:0]      r_cycles;
    logic             r_timeout;

    logic             w_found;
    logic [IDW-1:0]   w_winner;
    logic [IDW-1:0]   w_idx;
    int               w_j;
    logic             w_wd_hit;

    // Scan upward from the pointer, wrapping at NREQ-1; first set bit wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_j      = 0;
        w_idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_j = int'(r_ptr) + i;
            if (w_j >= NREQ) w_j = w_j - NREQ;
            w_idx = IDW'(w_j);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_wd_hit = (r_wd == WD_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_GO;
            S_GO:    w_next = S_RUN;
            S_RUN:   if (accel_done || w_wd_hit) w_next = S_DRAIN;
            S_DRAIN: if (!cnt_counting) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_wd      <= '0;
            r_tflag   <= 1'b0;
            r_cycles  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_winner;
                        r_ptr   <= (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
                    end
                end
                S_GO: r_wd <= '0;
                S_RUN: begin
                    // Cleared every GO, so it cannot reach wrap before the limit fires.
                    r_wd <= r_wd + 32'd1;
                    if (accel_done)    r_tflag <= 1'b0;
                    else if (w_wd_hit) r_tflag <= 1'b1;
                end
                S_DRAIN: begin
                    if (!cnt_counting) begin
                        r_cycles  <= cnt_value;
                        r_timeout <= r_tflag;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ack = '0;
        if (r_state == S_RESP) ack[r_grant] = 1'b1;
    end

    assign busy           = (r_state != S_IDLE);
    assign go_o           = (r_state == S_GO);
    assign result_valid   = (r_state == S_RESP);
    assign cnt_done_o     = ((r_state == S_RUN) && (accel_done || w_wd_hit)) ||
                            ((r_state == S_DRAIN) && cnt_counting);
    assign grant_id       = r_grant;
    assign result_cycles  = r_cycles;
    assign result_timeout = r_timeout;
    assign dbg_state      = r_state;

endmodule

// File: doc/run_scheduler.md
# run_scheduler

Round-robin run controller that shares one accelerator and its 64-bit cycle counter among `NREQ` requesters. It grants one requester at a time and issues a single-cycle start pulse to the accelerator and the counter together. It ends the measurement on accelerator done or on a watchdog timeout, then returns the captured cycle count to the winner with a one-cycle acknowledge. It sits between the host-side request logic and the accelerator/cycle-counter pair.

## Interface

- `NREQ`, 4: number of requesters, 2..16.
- `IDW`, 2: requester id width, equal to clog2(NREQ).
- `TIMEOUT`, 1_000_000: watchdog limit in RUN cycles, must be ≥2.

- `clk`: input, 1 bit. Single clock; all logic on rising edge.
- `reset_n`: input, 1 bit. Asynchronous, active-low reset.
- `req`: input, NREQ bits. Per-requester run request. Must be held high until the matching `ack` bit pulses.
- `ack`: output, NREQ bits. One-hot, one-cycle completion pulse to the winner.
- `busy`: output, 1 bit. High in every state except IDLE.
- `grant_id`: output, IDW bits. Id of the current or last winner.
- `go_o`: output, 1 bit. Start pulse, one cycle wide. Drives the accelerator start and the counter `go_i`.
- `accel_done`: input, 1 bit. Accelerator completion. Sampled only in RUN.
- `cnt_done_o`: output, 1 bit. Stop request to the counter `done` input.
- `cnt_counting`: input, 1 bit. Counter running flag.
- `cnt_value`: input, 64 bits. Counter `cycle_count`.
- `result_valid`: output, 1 bit. One-cycle pulse, coincident with `ack`.
- `result_cycles`: output, 64 bits. Captured count. Holds until the next RESP.
- `result_timeout`: output, 1 bit. Set if the run ended by watchdog. Holds with `result_cycles`.

## Operation

- **States:** IDLE, GO, RUN, DRAIN, RESP. The state register resets to IDLE.
- **Reset values:** all outputs 0. `grant_id` = 0, round-robin pointer = 0, watchdog = 0.
- **IDLE**
  - If `req` != 0, select the first set bit at or after the pointer, scanning upward and wrapping at NREQ−1→0.
  - Register the winner in `grant_id`, set pointer = (winner+1) mod NREQ, go to GO.
- **GO**
  - `go_o` = 1 for exactly this cycle. Clear the watchdog. Go to RUN.
- **RUN**
  - The watchdog increments each cycle.
  - If `accel_done` = 1: drive `cnt_done_o` = 1 this cycle, clear the timeout flag, go to DRAIN.
  - Else if watchdog == TIMEOUT−1: drive `cnt_done_o` = 1, set the timeout flag, go to DRAIN.
  - `accel_done` has priority when both conditions occur in the same cycle; the timeout flag stays 0.
- **DRAIN**
  - `cnt_done_o` = 1 while `cnt_counting` = 1.
  - When `cnt_counting` = 0: latch `cnt_value` into `result_cycles`, latch the flag into `result_timeout`, go to RESP.
- **RESP**
  - `ack[grant_id]` = 1 and `result_valid` = 1 for one cycle. Go to IDLE.
- **Ignored inputs:** `accel_done` outside RUN is ignored. `req` changes outside IDLE are ignored; a granted run completes even if its `req` drops.
- **`go_o`, `ack`, `result_valid`, `busy`** are state decodes. `cnt_done_o` is combinational from state and `accel_done`.
- **Watchdog** is 32 bits wide and never wraps, because it is cleared in GO.
- **Reset mid-run:** `reset_n` low forces IDLE immediately. No `ack` is issued; the counter shares the same reset.

## Timing

- `req` high in IDLE at cycle t: `go_o` high at t+1, RUN from t+2.
- Counter semantics (counter starts on `go_i`, increments each counting cycle without `done`, stops on `done` holding its value):
  - With `go_o` at cycle G and `accel_done` at cycle D, `result_cycles` = D−G−1.
  - DRAIN lasts 1 cycle and RESP is at D+2.
- Timeout: `cnt_done_o` at cycle G+TIMEOUT, `result_cycles` = TIMEOUT−1.
- Back-to-back runs: IDLE occupies one cycle between RESP and the next GO.
- Minimum period per run: 5 cycles (`accel_done` in the first RUN cycle).

## Test plan

- **Reset:** hold `reset_n` = 0 with `req` = 4'b1111 → all outputs 0. Release → `go_o` pulses 1 cycle later, `grant_id` = 0.
- **Single run:** `req[2]` = 1, `accel_done` 10 cycles after `go_o` → `ack` = 4'b0100, `result_cycles` = 9, `result_timeout` = 0, `result_valid` 2 cycles after done.
- **Round-robin:** `req` = 4'b1011 held, each run done immediately → grant order 0, 1, 3, 0, 1, 3; `ack` one-hot each time.
- **Timeout:** TIMEOUT = 16, `accel_done` never asserted → `cnt_done_o` at `go_o`+16, `result_cycles` = 15, `result_timeout` = 1.
- **Simultaneous events:** TIMEOUT = 16, `accel_done` on the final watchdog cycle → `result_timeout` = 0, `result_cycles` = 15. `accel_done` pulsed in IDLE → no effect.
- **Reset mid-run:** `reset_n` low for 1 cycle during RUN → `busy` = 0 immediately, no `ack`. The next request runs normally with `grant_id` restarting from pointer 0.
